squash_ctrl: RTL and testbench

SQUASH_CTRL -- requirements
Module: squash_ctrl

---
 rtl/squash_ctrl_pkg.sv | 26 ++
 rtl/squash_ctrl_age_cmp.sv | 19 +
 rtl/squash_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_squash_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/squash_ctrl_pkg.sv
// Shared backend types used by the squash controller.
// ROB/FTQ index formats and the squash broadcast bundle.
package squash_ctrl_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_IDX_W = 6;
    localparam int FTQ_IDX_W = 4;
    localparam int FTQ_OFF_W = 4;

    typedef struct packed {
        logic                 flip;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef logic [FTQ_IDX_W-1:0] ftqIdx_t;
    typedef logic [FTQ_OFF_W-1:0] ftqOffset_t;

    typedef struct packed {
        robIdx_t           robIdx;
        ftqIdx_t           ftqIdx;
        logic [XLEN-1:0]   target;
        logic              isExcept;
        logic [XLEN-1:0]   epc;
    } squashInfo_t;

endpackage

// File: rtl/squash_ctrl_age_cmp.sv
// Wrap-aware ROB age compare: older_o is set when a_i is strictly older
// than b_i; the flip bit toggles every lap around the ROB.
module rob_age_cmp
    import squash_ctrl_pkg::*;
(
    input  robIdx_t a_i,
    input  robIdx_t b_i,
    output logic    older_o
);

    always_comb begin
        if (a_i.flip == b_i.flip) begin
            older_o = (a_i.idx < b_i.idx);
        end else begin
            older_o = (a_i.idx > b_i.idx);
        end
    end

endmodule

// File: rtl/squash_ctrl.sv
// Picks the oldest branch mispredict or commit exception and issues
// a single squash pulse followed by a fixed-length recovery stall.
module squash_ctrl
    import squash_ctrl_pkg::*;
#(
    parameter int BRU_NUM        = 2,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BRU_NUM-1:0]  i_branchwb_vld,
    input  logic [BRU_NUM-1:0]  i_branchwb_mispred,
    input  robIdx_t             i_branchwb_robIdx [BRU_NUM],
    input  ftqIdx_t             i_branchwb_ftqIdx [BRU_NUM],
    input  logic [XLEN-1:0]     i_branchwb_npc    [BRU_NUM],
    input  logic                i_except_vld,
    input  robIdx_t             i_except_robIdx,
    input  ftqIdx_t             i_except_ftqIdx,
    input  ftqOffset_t          i_except_ftqOffset,
    input  logic [XLEN-1:0]     i_trap_vec,
    output ftqIdx_t             o_read_ftqIdx,
    input  logic [XLEN-1:0]     i_read_ftqStartAddr,
    output logic                o_squash_vld,
    output squashInfo_t         o_squashInfo,
    output logic                o_stall
);

    typedef enum logic [1:0] {
        IDLE,
        READ_FTQ,
        SQUASH,
        RECOVER
    } state_e;

    localparam int CW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    squashInfo_t       pend_q;
    ftqOffset_t        off_q;
    logic              vld_q;
    logic              stall_q;
    logic              armed_q;

    logic [BRU_NUM-1:0]         cand;
    logic [BRU_NUM-1:0]         win;
    logic [BRU_NUM*BRU_NUM-1:0] older_m;

    logic              br_vld;
    robIdx_t           br_rob;
    ftqIdx_t           br_ftq;
    logic [XLEN-1:0]   br_npc;
    logic              br_older_exc;
    logic              br_older_pend;
    logic              exc_win;
    squashInfo_t       br_info_d;
    squashInfo_t       exc_info_d;
    logic [XLEN-1:0]   epc_d;

    assign cand = i_branchwb_vld & i_branchwb_mispred;

    // Full pairwise age matrix: older_m[i*N+j] means port i older than port j.
    for (genvar gi = 0; gi < BRU_NUM; gi++) begin : g_row
        for (genvar gj = 0; gj < BRU_NUM; gj++) begin : g_col
            rob_age_cmp u_cmp (
                .a_i     (i_branchwb_robIdx[gi]),
                .b_i     (i_branchwb_robIdx[gj]),
                .older_o (older_m[gi*BRU_NUM+gj])
            );
        end
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < BRU_NUM; i++) begin
            win[i] = cand[i];
            for (int j = 0; j < BRU_NUM; j++) begin
                if (j != i && cand[j]) begin
                    if (j < i) begin
                        win[i] = win[i] & older_m[i*BRU_NUM+j];
                    end else begin
                        win[i] = win[i] & ~older_m[j*BRU_NUM+i];
                    end
                end
            end
        end
    end

    // Fallback to the lowest candidate if the ages are not a total order.
    always_comb begin
        br_vld = 1'b0;
        br_rob = '0;
        br_ftq = '0;
        br_npc = '0;
        for (int i = 0; i < BRU_NUM; i++) begin
            if (win[i] && !br_vld) begin
                br_vld = 1'b1;
                br_rob = i_branchwb_robIdx[i];
                br_ftq = i_branchwb_ftqIdx[i];
                br_npc = i_branchwb_npc[i];
            end
        end
        for (int i = 0; i < BRU_NUM; i++) begin
            if (cand[i] && !br_vld) begin
                br_vld = 1'b1;
                br_rob = i_branchwb_robIdx[i];
                br_ftq = i_branchwb_ftqIdx[i];
                br_npc = i_branchwb_npc[i];
            end
        end
    end

    rob_age_cmp u_cmp_exc (
        .a_i     (br_rob),
        .b_i     (i_except_robIdx),
        .older_o (br_older_exc)
    );

    rob_age_cmp u_cmp_pend (
        .a_i     (br_rob),
        .b_i     (pend_q.robIdx),
        .older_o (br_older_pend)
    );

    assign exc_win = i_except_vld && !(br_vld && br_older_exc);
    assign epc_d   = i_read_ftqStartAddr + XLEN'(off_q);

    always_comb begin
        br_info_d          = '0;
        br_info_d.robIdx   = br_rob;
        br_info_d.ftqIdx   = br_ftq;
        br_info_d.target   = br_npc;
        exc_info_d          = '0;
        exc_info_d.robIdx   = i_except_robIdx;
        exc_info_d.ftqIdx   = i_except_ftqIdx;
        exc_info_d.isExcept = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            off_q   <= '0;
            vld_q   <= 1'b0;
            stall_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            vld_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (armed_q && exc_win) begin
                        pend_q  <= exc_info_d;
                        off_q   <= i_except_ftqOffset;
                        state_q <= READ_FTQ;
                        stall_q <= 1'b1;
                    end else if (armed_q && br_vld) begin
                        pend_q  <= br_info_d;
                        state_q <= SQUASH;
                        vld_q   <= 1'b1;
                        stall_q <= 1'b1;
                    end
                end
                READ_FTQ: begin
                    if (br_vld && br_older_pend) begin
                        pend_q <= br_info_d;
                    end else begin
                        pend_q.target <= i_trap_vec;
                        pend_q.epc    <= epc_d;
                    end
                    state_q <= SQUASH;
                    vld_q   <= 1'b1;
                end
                SQUASH: begin
                    cnt_q   <= CW'(RECOVER_CYCLES - 1);
                    state_q <= RECOVER;
                end
                RECOVER: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        stall_q <= 1'b0;
                        pend_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
            endcase
        end
    end

    assign o_read_ftqIdx = (state_q == READ_FTQ) ? pend_q.ftqIdx : '0;
    assign o_squash_vld  = vld_q;
    assign o_squashInfo  = vld_q ? pend_q : '0;
    assign o_stall       = stall_q;

endmodule

// File: tb/tb_squash_ctrl.sv
// Directed-vector bench for squash_ctrl with hand-computed expectations.
module tb_squash_ctrl;
    import squash_ctrl_pkg::*;

    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      bvld;
    logic [N-1:0]      bmis;
    robIdx_t           brob [N];
    ftqIdx_t           bftq [N];
    logic [XLEN-1:0]   bnpc [N];
    logic              evld;
    robIdx_t           erob;
    ftqIdx_t           eftq;
    ftqOffset_t        eoff;
    logic [XLEN-1:0]   trap;
    ftqIdx_t           rd_idx;
    logic [XLEN-1:0]   rd_addr;
    logic              sq_vld;
    squashInfo_t       sq_info;
    logic              stall;

    int n_chk  = 0;
    int n_pass = 0;

    squashInfo_t exp_i;

    always #5 clk = ~clk;

    // FTQ model: only index 7 holds a real start address.
    assign rd_addr = (rd_idx == 4'd7) ? 32'h0000_1000 : 32'hDEAD_0000;

    squash_ctrl #(.BRU_NUM(N), .RECOVER_CYCLES(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_branchwb_vld      (bvld),
        .i_branchwb_mispred  (bmis),
        .i_branchwb_robIdx   (brob),
        .i_branchwb_ftqIdx   (bftq),
        .i_branchwb_npc      (bnpc),
        .i_except_vld        (evld),
        .i_except_robIdx     (erob),
        .i_except_ftqIdx     (eftq),
        .i_except_ftqOffset  (eoff),
        .i_trap_vec          (trap),
        .o_read_ftqIdx       (rd_idx),
        .i_read_ftqStartAddr (rd_addr),
        .o_squash_vld        (sq_vld),
        .o_squashInfo        (sq_info),
        .o_stall             (stall)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bvld = '0;
        bmis = '0;
        for (int i = 0; i < N; i++) begin
            brob[i] = '0;
            bftq[i] = '0;
            bnpc[i] = '0;
        end
        evld = 1'b0;
        erob = '0;
        eftq = '0;
        eoff = '0;
    endtask

    task automatic br(input int p, input logic f, input int idx,
                      input int ftq, input logic [XLEN-1:0] npc);
        bvld[p] = 1'b1;
        bmis[p] = 1'b1;
        brob[p] = '{flip: f, idx: ROB_IDX_W'(idx)};
        bftq[p] = FTQ_IDX_W'(ftq);
        bnpc[p] = npc;
    endtask

    task automatic ex(input logic f, input int idx, input int ftq,
                      input int off);
        evld = 1'b1;
        erob = '{flip: f, idx: ROB_IDX_W'(idx)};
        eftq = FTQ_IDX_W'(ftq);
        eoff = FTQ_OFF_W'(off);
    endtask

    task automatic set_exp(input logic f, input int idx, input int ftq,
                           input logic [XLEN-1:0] tgt, input logic isx,
                           input logic [XLEN-1:0] epc);
        exp_i          = '0;
        exp_i.robIdx   = '{flip: f, idx: ROB_IDX_W'(idx)};
        exp_i.ftqIdx   = FTQ_IDX_W'(ftq);
        exp_i.target   = tgt;
        exp_i.isExcept = isx;
        exp_i.epc      = epc;
    endtask

    // Four RECOVER cycles, then back in IDLE with stall released.
    task automatic drain(input string tag);
        for (int k = 0; k < 4; k++) begin
            step();
            chk({tag, "_rec_stall"}, stall, 1);
            chk({tag, "_rec_vld"}, sq_vld, 0);
        end
        step();
        chk({tag, "_idle_stall"}, stall, 0);
    endtask

    initial begin
        trap = 32'h0000_0200;
        clr();
        rst = 1'b1;
        step();
        step();
        chk("rst_vld", sq_vld, 0);
        chk("rst_stall", stall, 0);
        chk("rst_info", sq_info, 0);
        chk("rst_rd", rd_idx, 0);

        // First cycle after reset release must not sample.
        rst = 1'b0;
        br(0, 0, 9, 1, 32'h1234_0000);
        step();
        clr();
        chk("post_rst_vld", sq_vld, 0);
        chk("post_rst_stall", stall, 0);

        // vld without mispred is not a candidate.
        bvld[0] = 1'b1;
        step();
        clr();
        chk("nomis_vld", sq_vld, 0);
        chk("nomis_stall", stall, 0);

        // Single mispredict on port 1.
        br(1, 0, 5, 3, 32'h8000_0100);
        step();
        clr();
        set_exp(0, 5, 3, 32'h8000_0100, 0, 0);
        chk("br_vld", sq_vld, 1);
        chk("br_info", sq_info, exp_i);
        chk("br_stall", stall, 1);
        drain("br");
        chk("br_info_zero", sq_info, 0);

        // Wrap-around age: {0,60} is older than {1,2}.
        br(0, 1, 2, 1, 32'h0000_A000);
        br(1, 0, 60, 2, 32'h0000_B000);
        step();
        clr();
        set_exp(0, 60, 2, 32'h0000_B000, 0, 0);
        chk("wrap_vld", sq_vld, 1);
        chk("wrap_info", sq_info, exp_i);
        drain("wrap");

        // Identical robIdx on both ports: port 0 wins.
        br(0, 0, 20, 4, 32'h0000_C000);
        br(1, 0, 20, 5, 32'h0000_D000);
        step();
        clr();
        set_exp(0, 20, 4, 32'h0000_C000, 0, 0);
        chk("tie_info", sq_info, exp_i);
        drain("tie");

        // Exception: FTQ read, then squash with epc.
        ex(0, 3, 7, 8);
        step();
        clr();
        chk("exc_rd", rd_idx, 7);
        chk("exc_rd_vld", sq_vld, 0);
        chk("exc_rd_stall", stall, 1);
        step();
        set_exp(0, 3, 7, 32'h0000_0200, 1, 32'h0000_1008);
        chk("exc_vld", sq_vld, 1);
        chk("exc_info", sq_info, exp_i);
        chk("exc_rd_off", rd_idx, 0);
        drain("exc");

        // Exception and branch with the same robIdx: exception wins.
        ex(0, 12, 7, 2);
        br(0, 0, 12, 9, 32'h0000_E000);
        step();
        chk("xtie_rd", rd_idx, 7);
        step();
        clr();
        set_exp(0, 12, 7, 32'h0000_0200, 1, 32'h0000_1002);
        chk("xtie_info", sq_info, exp_i);
        drain("xtie");

        // Older mispredict during READ_FTQ replaces the exception.
        ex(0, 10, 2, 1);
        step();
        clr();
        chk("repl_rd", rd_idx, 2);
        br(0, 0, 4, 5, 32'h0000_4000);
        step();
        clr();
        set_exp(0, 4, 5, 32'h0000_4000, 0, 0);
        chk("repl_vld", sq_vld, 1);
        chk("repl_info", sq_info, exp_i);
        drain("repl");

        // Mispredict held through RECOVER is ignored.
        br(0, 0, 1, 1, 32'h0000_0040);
        step();
        clr();
        chk("rec_first", sq_vld, 1);
        br(1, 0, 2, 2, 32'h0000_0080);
        drain("rec");
        clr();
        step();
        chk("rec_no_second", sq_vld, 0);
        chk("rec_no_stall", stall, 0);

        // Reset asserted while in SQUASH.
        br(0, 0, 7, 3, 32'h0000_0700);
        step();
        clr();
        chk("mid_vld_pre", sq_vld, 1);
        rst = 1'b1;
        #1;
        chk("mid_vld", sq_vld, 0);
        chk("mid_stall", stall, 0);
        chk("mid_info", sq_info, 0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("mid_after_stall", stall, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
